// File: rtl/inverse_filter.sv
// Recovers x[n] from y[n] = a*y[n-1] + b*x[n] using a bit-serial restoring divider.
// Define INV_FILTER_ERR_EN to enable remainder/overflow flags and 8-bit output saturation.
module inverse_filter #(
    parameter logic [31:0] A_COEF = 32'd2,
    parameter logic [31:0] B_COEF = 32'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] y_in,
    input  logic        y_valid,
    output logic        y_ready,
    output logic [7:0]  x_out,
    output logic        x_valid,
    input  logic        x_ready,
    output logic        rem_err,
    output logic        ovf_err
);

    typedef enum logic [1:0] {IDLE, SUB, DIV, DONE} state_t;

    state_t      state_q;
    logic [31:0] y_lat_q;
    logic [31:0] y_prev_q;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [4:0]  cnt_q;
    logic [7:0]  x_out_q;
    logic        x_valid_q;
    logic        rem_err_q;
    logic        ovf_err_q;

    logic [31:0] d_d;
    logic [32:0] rem_shift_d;
    logic [32:0] rem_diff_d;
    logic        fits_d;
    logic [31:0] rem_d;
    logic [31:0] quo_d;
    logic [7:0]  x_res_d;
    logic        rem_err_d;
    logic        ovf_err_d;

    // quo_q starts as the dividend and shifts quotient bits in from the right.
    always_comb begin
        d_d         = y_lat_q - A_COEF * y_prev_q;
        rem_shift_d = {rem_q, quo_q[31]};
        rem_diff_d  = rem_shift_d - {1'b0, B_COEF};
        fits_d      = (rem_shift_d >= {1'b0, B_COEF});
        rem_d       = fits_d ? rem_diff_d[31:0] : rem_shift_d[31:0];
        quo_d       = {quo_q[30:0], fits_d};
`ifdef INV_FILTER_ERR_EN
        ovf_err_d   = |quo_d[31:8];
        rem_err_d   = |rem_d;
        x_res_d     = ovf_err_d ? 8'hFF : quo_d[7:0];
`else
        ovf_err_d   = 1'b0;
        rem_err_d   = 1'b0;
        x_res_d     = quo_d[7:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            y_lat_q   <= '0;
            y_prev_q  <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            x_out_q   <= '0;
            x_valid_q <= 1'b0;
            rem_err_q <= 1'b0;
            ovf_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // y_in is captured here so later changes on the bus cannot corrupt d.
                    if (y_valid) begin
                        y_lat_q <= y_in;
                        state_q <= SUB;
                    end
                end
                SUB: begin
                    quo_q    <= d_d;
                    rem_q    <= '0;
                    cnt_q    <= '0;
                    y_prev_q <= y_lat_q;
                    state_q  <= DIV;
                end
                DIV: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        x_out_q   <= x_res_d;
                        rem_err_q <= rem_err_d;
                        ovf_err_q <= ovf_err_d;
                        x_valid_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (x_ready) begin
                        x_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign y_ready = (state_q == IDLE) && !reset;
    assign x_out   = x_out_q;
    assign x_valid = x_valid_q;
    assign rem_err = rem_err_q;
    assign ovf_err = ovf_err_q;

endmodule

// File: tb/tb_inverse_filter.sv
// Scoreboard bench for inverse_filter: a reference model pushes expected samples on each
// accepted y_in; they are popped and compared when x_valid rises.
module tb_inverse_filter;

    localparam logic [31:0] A = 32'd2;
    localparam logic [31:0] B = 32'd3;
    localparam int LAT = 34;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] y_in = '0;
    logic        y_valid = 1'b0;
    logic        y_ready;
    logic [7:0]  x_out;
    logic        x_valid;
    logic        x_ready = 1'b1;
    logic        rem_err;
    logic        ovf_err;

    inverse_filter #(.A_COEF(A), .B_COEF(B)) dut (
        .clk(clk), .reset(reset), .y_in(y_in), .y_valid(y_valid), .y_ready(y_ready),
        .x_out(x_out), .x_valid(x_valid), .x_ready(x_ready),
        .rem_err(rem_err), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] x;
        logic       r;
        logic       o;
        int         t;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] y_prev_m = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: arithmetic divide of the wrapped difference, then flag/saturate.
    function automatic exp_t model(input logic [31:0] y, input logic [31:0] prev);
        exp_t        e;
        logic [31:0] d, q, r;
        d = y - A * prev;
        q = d / B;
        r = d % B;
`ifdef INV_FILTER_ERR_EN
        e.o = (q > 32'd255);
        e.r = (r != 0);
        e.x = e.o ? 8'd255 : q[7:0];
`else
        e.o = 1'b0;
        e.r = 1'b0;
        e.x = q[7:0];
`endif
        e.t = 0;
        return e;
    endfunction

    task automatic do_reset();
        reset   = 1'b1;
        y_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_y_ready_low", {31'd0, y_ready}, 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        y_prev_m = '0;
        sb.delete();
        @(negedge clk);
        check_eq("rst_y_ready", {31'd0, y_ready}, 32'd1);
        check_eq("rst_x_valid", {31'd0, x_valid}, 32'd0);
        check_eq("rst_x_out", {24'd0, x_out}, 32'd0);
        check_eq("rst_flags", {30'd0, rem_err, ovf_err}, 32'd0);
    endtask

    // Called at a negedge; returns one negedge after the accepting edge.
    task automatic send(input logic [31:0] y);
        exp_t e;
        int   w;
        w = 0;
        while (!y_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!y_ready) check_eq("send_timeout", 32'd0, 32'd1);
        y_in    = y;
        y_valid = 1'b1;
        e       = model(y, y_prev_m);
        e.t     = cyc;
        sb.push_back(e);
        y_prev_m = y;
        $display("drive y_in=%0d exp x_out=%0d rem=%0d ovf=%0d", y, e.x, e.r, e.o);
        @(negedge clk);
        y_valid = 1'b0;
        y_in    = 32'hDEAD_BEEF;
    endtask

    // Wait for x_valid, compare against the scoreboard head; optionally stall x_ready.
    task automatic collect(input string tag, input int hold);
        exp_t e;
        int   w;
        w = 0;
        while (!x_valid && w < 80) begin
            @(negedge clk);
            w++;
        end
        if (!x_valid) begin
            check_eq({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        if (sb.size() == 0) begin
            check_eq({tag, "_unexpected"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        $display("recv %s x_out=%0d rem=%0d ovf=%0d latency=%0d", tag, x_out, rem_err, ovf_err, cyc - e.t);
        check_eq({tag, "_latency"}, cyc - e.t, LAT);
        check_eq({tag, "_x_out"}, {24'd0, x_out}, {24'd0, e.x});
        check_eq({tag, "_rem_err"}, {31'd0, rem_err}, {31'd0, e.r});
        check_eq({tag, "_ovf_err"}, {31'd0, ovf_err}, {31'd0, e.o});
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_eq({tag, "_hold_valid"}, {31'd0, x_valid}, 32'd1);
                check_eq({tag, "_hold_x_out"}, {24'd0, x_out}, {24'd0, e.x});
                check_eq({tag, "_hold_y_ready"}, {31'd0, y_ready}, 32'd0);
            end
            x_ready = 1'b1;
        end
        @(negedge clk);
        check_eq({tag, "_valid_drop"}, {31'd0, x_valid}, 32'd0);
        check_eq({tag, "_idle_ready"}, {31'd0, y_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        @(negedge clk);
        do_reset();

        send(32'd15);
        collect("y15", 0);
        send(32'd51);
        collect("y51", 0);

        do_reset();
        send(32'd16);
        collect("y16_rem", 0);

        do_reset();
        send(32'd3000);
        collect("y3000_ovf", 0);
        send(32'd9);
        collect("y9_wrap_ovf", 0);

        do_reset();
        send(32'h8000_0000);
        collect("y80000000", 0);
        send(32'd9);
        collect("y9_wrap_ok", 0);

        do_reset();
        x_ready = 1'b0;
        send(32'd15);
        collect("stall", 10);

        // Abort during the tenth divide iteration; nothing may come out.
        do_reset();
        send(32'd100);
        repeat (10) @(negedge clk);
        do_reset();
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (x_valid) seen++;
        end
        check_eq("abort_no_xvalid", seen, 0);
        send(32'd15);
        collect("after_abort", 0);

        for (int i = 0; i < 6; i++) begin
            send($urandom_range(0, 2000));
            collect("rand", 0);
        end

        check_eq("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inverse_filter.md
INVERSE_FILTER -- requirements
Module: inverse_filter

Interface
REQ-001 SHALL have parameter A_COEF, default 2, 32-bit feedback coefficient a of the forward filter.
REQ-002 SHALL have parameter B_COEF, default 3, 32-bit input coefficient b of the forward filter; nonzero.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port y_in  input  32  filtered sample y[n].
REQ-006 SHALL have port y_valid  input  1  y_in valid.
REQ-007 SHALL have port y_ready  output  1  block accepts y_in.
REQ-008 SHALL have port x_out  output  8  recovered input sample x[n].
REQ-009 SHALL have port x_valid  output  1  x_out valid.
REQ-010 SHALL have port x_ready  input  1  downstream accepts x_out.
REQ-011 SHALL have port rem_err  output  1  division remainder nonzero for current x_out.
REQ-012 SHALL have port ovf_err  output  1  quotient exceeded 255 for current x_out.

Function
REQ-013 SHALL invert y[n] = a*y[n-1] + b*x[n]: x[n] = (y[n] - a*y[n-1]) / b.
REQ-014 SHALL compute d = (y_in - A_COEF*y_prev) modulo 2^32, unsigned; y_prev is the last accepted y_in, 0 after reset.
REQ-015 SHALL divide d by B_COEF with a 32-iteration restoring shift-subtract divider, one quotient bit per cycle; no combinational divide.
REQ-016 SHALL use FSM states IDLE, SUB, DIV, DONE.
REQ-017 IDLE: y_ready=1; on y_valid&y_ready go to SUB.
REQ-018 SUB: register d, y_prev<=y_in value, clear iteration counter; go to DIV.
REQ-019 DIV: one iteration per cycle; after 32nd iteration go to DONE.
REQ-020 DONE: x_valid=1; x_out, rem_err, ovf_err held stable; on x_ready go to IDLE.
REQ-021 Latency: handshake in cycle T -> x_valid first high in cycle T+34; back-to-back throughput 1 sample per 35 cycles minimum.
REQ-022 y_ready SHALL be 0 in SUB, DIV, DONE; y_in ignored there.
REQ-023 Quotient >255: x_out=255 (saturate), ovf_err=1; otherwise x_out=quotient[7:0], ovf_err=0.
REQ-024 rem_err=1 iff remainder !=0.
REQ-025 x_ready held low in DONE: all outputs held indefinitely, no new sample accepted.
REQ-026 x_ready high outside DONE: no effect.

Reset
REQ-027 reset high at a clock edge SHALL force IDLE, y_prev=0, x_out=0, x_valid=0, rem_err=0, ovf_err=0, divider registers 0.
REQ-028 y_ready SHALL be 0 while reset is high.
REQ-029 reset mid-operation (SUB/DIV/DONE) SHALL abort the sample with no output and without updating y_prev beyond reset value.

Configuration
REQ-030 Macro INV_FILTER_ERR_EN defined: rem_err and ovf_err computed per REQ-023/024, x_out saturates.
REQ-031 INV_FILTER_ERR_EN undefined: rem_err and ovf_err tied 0, x_out=quotient[7:0] (no saturation); ports remain present.

Verification
REQ-032 After reset, y_in=15 -> x_out=5 at T+34, rem_err=0, ovf_err=0; then y_in=51 -> x_out=7.
REQ-033 After reset, y_in=16 -> x_out=5, rem_err=1 (INV_FILTER_ERR_EN defined).
REQ-034 After reset, y_in=3000 -> x_out=255, ovf_err=1; then y_in=0x00000009 (d wraps: 9-6000 mod 2^32) -> ovf_err=1; separate run y_in=0x80000000 then 9 -> second x_out=3, no errors (wrap).
REQ-035 x_ready low 10 cycles in DONE -> x_valid, x_out stable, y_ready=0 throughout; release -> IDLE next cycle.
REQ-036 reset pulsed in DIV cycle 10 -> no x_valid, next y_in=15 -> x_out=5 (y_prev was 0).
